// File: rtl/apb_seq_master_pkg.sv
// rtl/apb_seq_master_pkg.sv - register offsets, encodings, FSM state and per-step decode for apb_seq_master
package apb_seq_master_pkg;

    localparam logic [5:0] OFF_CONFIG = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h00;
    localparam logic [5:0] OFF_TX     = 6'h04;
    localparam logic [5:0] OFF_RX     = 6'h04;
    localparam logic [5:0] OFF_CMD    = 6'h0C;
    localparam logic [7:0] CMD_START  = 8'h02;

    localparam logic OP_WRITE  = 1'b0;
    localparam logic OP_READ   = 1'b1;
    localparam logic RD_STATUS = 1'b0;
    localparam logic RD_RX     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic       write;
        logic [5:0] offset;
        logic [7:0] wdata;
    } step_t;

    // Decode which register a given step of a request touches and with what data.
    function automatic step_t step_cfg(input logic op, input logic rd_sel, input logic [1:0] step,
                                       input logic [1:0] mode, input logic [1:0] slave,
                                       input logic [1:0] sck, input logic [7:0] data);
        step_t s;
        s = '{write: 1'b0, offset: OFF_STATUS, wdata: 8'h00};
        if (op == OP_READ) begin
            s.offset = (rd_sel == RD_RX) ? OFF_RX : OFF_STATUS;
        end else begin
            s.write = 1'b1;
            case (step)
                2'd0:    begin s.offset = OFF_CONFIG; s.wdata = {2'b00, mode, slave, sck}; end
                2'd1:    begin s.offset = OFF_TX;     s.wdata = data;                      end
                default: begin s.offset = OFF_CMD;    s.wdata = CMD_START;                 end
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/apb_seq_master_xfer.sv
// rtl/apb_seq_master_xfer.sv - apb_xfer: one APB SETUP/ACCESS transfer with PREADY wait (timeout under APB_SEQ_MASTER_TIMEOUT_EN)
module apb_xfer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_write,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    input  logic        i_PREADY,
    output logic        o_PSEL,
    output logic        o_PENABLE,
    output logic        o_PWRITE,
    output logic [15:0] o_PADDR,
    output logic [7:0]  o_PWDATA,
    output logic        o_end,
    output logic        o_timeout
);

    logic        psel_q, penable_q, pwrite_q;
    logic [15:0] paddr_q;
    logic [7:0]  pwdata_q;
    logic        in_access;

    assign in_access = psel_q & penable_q;
    assign o_end     = in_access & i_PREADY;

`ifdef APB_SEQ_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_q, wait_d;

    assign o_timeout = in_access & ~i_PREADY & (wait_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d = wait_q;
        if (i_start)
            wait_d = '0;
        else if (in_access & ~i_PREADY)
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) wait_q <= '0;
        else       wait_q <= wait_d;
    end
`else
    assign o_timeout = 1'b0;
`endif

    // Address and data are only loaded on start so they hold through GAP/IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else if (i_start) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= i_write;
            paddr_q   <= i_addr;
            pwdata_q  <= i_wdata;
        end else if (psel_q & ~penable_q) begin
            penable_q <= 1'b1;
        end else if (o_end | o_timeout) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
        end
    end

    assign o_PSEL    = psel_q;
    assign o_PENABLE = penable_q;
    assign o_PWRITE  = pwrite_q;
    assign o_PADDR   = paddr_q;
    assign o_PWDATA  = pwdata_q;

endmodule

// File: rtl/apb_seq_master.sv
// rtl/apb_seq_master.sv - APB initiator sequencing SPI byte launches and register reads; APB_SEQ_MASTER_TIMEOUT_EN enables PREADY timeout
module apb_seq_master #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        i_PCLK,
    input  logic        i_PRESET,
    input  logic [9:0]  i_BASE_ADDR,
    input  logic        i_req,
    input  logic        i_op,
    input  logic        i_rd_sel,
    input  logic [1:0]  i_mode,
    input  logic [1:0]  i_slave,
    input  logic [1:0]  i_sck,
    input  logic [7:0]  i_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_rdata,
    output logic        o_PSEL,
    output logic        o_PENABLE,
    output logic        o_PWRITE,
    output logic [15:0] o_PADDR,
    output logic [7:0]  o_PWDATA,
    input  logic [7:0]  i_PRDATA,
    input  logic        i_PREADY
);
    import apb_seq_master_pkg::*;

    state_t     state_q;
    logic [1:0] step_q;
    logic       op_q, rd_sel_q;
    logic [1:0] mode_q, slave_q, sck_q;
    logic [7:0] data_q;
    logic [9:0] base_q;
    logic       busy_q, done_q, err_q;
    logic [7:0] rdata_q;

    logic       accept, xfer_start, xfer_end, xfer_timeout, last_step;
    logic [9:0] cur_base;
    step_t      cur;

    assign accept     = (state_q == ST_IDLE) && i_req;
    assign xfer_start = accept || (state_q == ST_GAP);
    assign last_step  = (op_q == OP_READ) || (step_q == 2'd2);
    assign cur_base   = accept ? i_BASE_ADDR : base_q;

    // On accept the latches are not loaded yet, so step 0 decodes straight from the request inputs.
    always_comb begin
        if (state_q == ST_IDLE)
            cur = step_cfg(i_op, i_rd_sel, 2'd0, i_mode, i_slave, i_sck, i_data);
        else
            cur = step_cfg(op_q, rd_sel_q, step_q, mode_q, slave_q, sck_q, data_q);
    end

    apb_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_xfer (
        .i_clk     (i_PCLK),
        .i_rst     (i_PRESET),
        .i_start   (xfer_start),
        .i_write   (cur.write),
        .i_addr    ({cur_base, cur.offset}),
        .i_wdata   (cur.wdata),
        .i_PREADY  (i_PREADY),
        .o_PSEL    (o_PSEL),
        .o_PENABLE (o_PENABLE),
        .o_PWRITE  (o_PWRITE),
        .o_PADDR   (o_PADDR),
        .o_PWDATA  (o_PWDATA),
        .o_end     (xfer_end),
        .o_timeout (xfer_timeout)
    );

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            state_q  <= ST_IDLE;
            step_q   <= 2'd0;
            op_q     <= 1'b0;
            rd_sel_q <= 1'b0;
            mode_q   <= '0;
            slave_q  <= '0;
            sck_q    <= '0;
            data_q   <= '0;
            base_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: if (i_req) begin
                    state_q  <= ST_SETUP;
                    step_q   <= 2'd0;
                    op_q     <= i_op;
                    rd_sel_q <= i_rd_sel;
                    mode_q   <= i_mode;
                    slave_q  <= i_slave;
                    sck_q    <= i_sck;
                    data_q   <= i_data;
                    base_q   <= i_BASE_ADDR;
                    busy_q   <= 1'b1;
                end
                ST_SETUP: state_q <= ST_ACCESS;
                ST_ACCESS: begin
                    if (xfer_timeout) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (xfer_end && last_step) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (op_q == OP_READ) rdata_q <= i_PRDATA;
                    end else if (xfer_end) begin
                        state_q <= ST_GAP;
                        step_q  <= step_q + 2'd1;
                    end
                end
                default: state_q <= ST_SETUP;
            endcase
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_apb_seq_master.sv
// tb/tb_apb_seq_master.sv - self-checking bench for apb_seq_master
module tb_apb_seq_master;

`ifdef APB_SEQ_MASTER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  base;
    logic        req, op, rd_sel;
    logic [1:0]  mode, slave, sck;
    logic [7:0]  data;
    logic        busy, done, err;
    logic [7:0]  rdata;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        pready;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_rdata;

    always #5 clk = ~clk;

    apb_seq_master #(.TIMEOUT_CYCLES(TO)) dut (
        .i_PCLK(clk), .i_PRESET(rst), .i_BASE_ADDR(base), .i_req(req), .i_op(op),
        .i_rd_sel(rd_sel), .i_mode(mode), .i_slave(slave), .i_sck(sck), .i_data(data),
        .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
        .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite), .o_PADDR(paddr),
        .o_PWDATA(pwdata), .i_PRDATA(prdata), .i_PREADY(pready)
    );

    task automatic test_reset();
        int acc_seen;
        rst = 1'b1; req = 1'b0; op = 1'b0; rd_sel = 1'b0; mode = '0; slave = '0; sck = '0;
        data = '0; base = '0; prdata = '0; pready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, rdata, psel, penable, pwrite, paddr, pwdata} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {busy, done, err, rdata, psel, penable, pwrite, paddr, pwdata});
        end
        rst = 1'b0;
        model_rdata = 8'h00;
        // start a write, then reset while the first transfer sits in ACCESS
        base = 10'd3; op = 1'b0; data = 8'h5A; req = 1'b1;
        @(posedge clk);
        acc_seen = 0;
        for (int c = 0; c < 10 && acc_seen == 0; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (psel && penable) acc_seen = 1;
        end
        checks++;
        if (acc_seen != 1) begin
            errors++;
            $display("FAIL reset_reach_access got=%0d exp=1", acc_seen);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, err, rdata, psel, penable, pwrite, paddr, pwdata} !== 38'd0) begin
                errors++;
                $display("FAIL reset_mid_access got=%h exp=0", {busy, done, err, rdata, psel, penable, pwrite, paddr, pwdata});
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || psel !== 1'b0) begin
                errors++;
                $display("FAIL reset_abandon done=%b busy=%b psel=%b exp=0", done, busy, psel);
            end
        end
    endtask

    // Drive one request and act as the APB slave, inserting w0..w2 wait cycles per transfer.
    task automatic do_seq(input logic op_i, input logic rd_i, input logic [1:0] mode_i,
                          input logic [1:0] slave_i, input logic [1:0] sck_i, input logic [7:0] data_i,
                          input logic [9:0] base_i, input logic [7:0] prd_i, input int w0, input int w1,
                          input int w2, input bit pulse_busy, input bit hold_req);
        logic [15:0] ea[3];
        logic [7:0]  ed[3];
        int          wt[3];
        int          n, exp_done, k, acc;
        bit          finished;
        logic [15:0] setup_addr;
        wt = '{w0, w1, w2};
        if (op_i == 1'b0) begin
            n = 3;
            ea[0] = {base_i, 6'h00}; ed[0] = {2'b00, mode_i, slave_i, sck_i};
            ea[1] = {base_i, 6'h04}; ed[1] = data_i;
            ea[2] = {base_i, 6'h0C}; ed[2] = 8'h02;
        end else begin
            n = 1;
            ea[0] = {base_i, rd_i ? 6'h04 : 6'h00}; ed[0] = 8'h00;
        end
        exp_done = 1 + (n - 1);
        for (int i = 0; i < n; i++) exp_done += 2 + wt[i];

        @(negedge clk);
        op = op_i; rd_sel = rd_i; mode = mode_i; slave = slave_i; sck = sck_i; data = data_i;
        base = base_i; prdata = prd_i; pready = 1'b0; req = 1'b1;
        @(posedge clk);
        k = 0; acc = 0; finished = 0; setup_addr = '0;
        for (int cyc = 1; cyc <= 80 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !hold_req) req = 1'b0;
            if (pulse_busy && cyc == 2) begin req = 1'b1; op = ~op_i; end
            if (pulse_busy && cyc == 3) begin req = 1'b0; op = op_i; end
            pready = 1'b0;
            if (cyc == exp_done) begin
                finished = 1;
                checks++;
                if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || psel !== 1'b0) begin
                    errors++;
                    $display("FAIL done_cycle cyc=%0d done=%b err=%b busy=%b psel=%b exp 1/0/0/0", cyc, done, err, busy, psel);
                end
                if (op_i) model_rdata = prd_i;
                checks++;
                if (rdata !== model_rdata) begin
                    errors++;
                    $display("FAIL rdata got=%h exp=%h", rdata, model_rdata);
                end
                checks++;
                if (k != n) begin
                    errors++;
                    $display("FAIL xfer_count got=%0d exp=%0d", k, n);
                end
            end else begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_phase cyc=%0d done=%b busy=%b exp done=0 busy=1", cyc, done, busy);
                end
                if (psel && !penable) begin
                    setup_addr = paddr;
                end else if (psel && penable) begin
                    if (k >= n) begin
                        errors++; checks++;
                        $display("FAIL extra_xfer addr=%h exp none", paddr);
                        pready = 1'b1;
                    end else begin
                        if (acc >= wt[k]) pready = 1'b1;
                        acc++;
                        if (pready) begin
                            checks++;
                            if (paddr !== ea[k] || paddr !== setup_addr || pwrite !== ~op_i ||
                                (!op_i && pwdata !== ed[k])) begin
                                errors++;
                                $display("FAIL xfer%0d addr=%h setup_addr=%h wr=%b wd=%h exp addr=%h wr=%b wd=%h",
                                         k, paddr, setup_addr, pwrite, pwdata, ea[k], ~op_i, ed[k]);
                            end
                            k++; acc = 0;
                        end
                    end
                end else begin
                    checks++;
                    if (penable !== 1'b0 || pwrite !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_ctl penable=%b pwrite=%b exp 0/0", penable, pwrite);
                    end
                end
            end
        end
        if (!finished) begin
            errors++; checks++;
            $display("FAIL seq_timeout got=no_done exp=done_at_%0d", exp_done);
        end
    endtask

    task automatic test_write_directed();
        do_seq(1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 8'h81, 10'd1, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_read_wait();
        do_seq(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 10'd1, 8'hA5, 2, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        do_seq(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 10'd1, 8'h3C, 0, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL busy_req_queued busy=%b psel=%b exp 0/0", busy, psel);
        end
        do_seq(1'b0, 1'b0, 2'b10, 2'b01, 2'b11, 8'hF0, 10'h3FF, 8'h00, 1, 3, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            do_seq(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                   10'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        do_seq(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 10'd2, 8'h77, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || busy !== 1'b1 || paddr !== {10'd2, 6'h04}) begin
            errors++;
            $display("FAIL b2b_setup psel=%b penable=%b busy=%b addr=%h exp 1/0/1/0084", psel, penable, busy, paddr);
        end
        req = 1'b0;
        prdata = 8'h19;
        got = 0;
        for (int cyc = 2; cyc <= 20 && got == 0; cyc++) begin
            @(negedge clk);
            pready = psel & penable;
            if (done) got = cyc;
        end
        pready = 1'b0;
        model_rdata = 8'h19;
        checks++;
        if (got != 3 || rdata !== model_rdata) begin
            errors++;
            $display("FAIL b2b_second done_cyc=%0d rdata=%h exp 3/%h", got, rdata, model_rdata);
        end
    endtask

`ifdef APB_SEQ_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int k, waits, got;
        bit saw_cmd, got_err;
        @(negedge clk);
        op = 1'b0; base = 10'd5; mode = 2'b01; slave = 2'b00; sck = 2'b10; data = 8'hEE; req = 1'b1;
        @(posedge clk);
        k = 0; waits = 0; got = 0; saw_cmd = 0; got_err = 0;
        for (int cyc = 1; cyc <= 40 && got == 0; cyc++) begin
            @(negedge clk);
            req = 1'b0;
            pready = 1'b0;
            if (psel && paddr[5:0] == 6'h0C) saw_cmd = 1;
            if (psel && penable) begin
                if (k == 0) begin pready = 1'b1; k = 1; end
                else waits++;
            end
            if (done) begin got = cyc; got_err = err; end
        end
        checks++;
        if (got != 9 || got_err !== 1'b1 || saw_cmd || waits != TO || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout done_cyc=%0d err=%b cmd=%b waits=%0d busy=%b exp 9/1/0/%0d/0",
                     got, got_err, saw_cmd, waits, busy, TO);
        end
        checks++;
        if (rdata !== model_rdata) begin
            errors++;
            $display("FAIL timeout_rdata got=%h exp=%h", rdata, model_rdata);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse done=%b err=%b psel=%b exp 0/0/0", done, err, psel);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_directed();
        test_read_wait();
        test_busy_ignore();
        test_random();
        test_back_to_back();
`ifdef APB_SEQ_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
